// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD/binary converter slice.
// Holds the FSM state enum, the digit constants and a clog2 helper.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam int BCD_DIGIT_W = 4;

  localparam logic [BCD_DIGIT_W-1:0]
    BCD_MAX_DIGIT  = 4'd9;
  localparam logic [BCD_DIGIT_W-1:0]
    BCD_ADJ_THRESH = 4'd8;
  localparam logic [BCD_DIGIT_W-1:0]
    BCD_ADD_THRESH = 4'd5;
  localparam logic [BCD_DIGIT_W-1:0]
    BCD_ADJ_VAL    = 4'd3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Per-digit double-dabble correction, purely combinational.
// Ports: din (4-bit digit), dout (corrected digit). ADD=1 gives +3 form.
module bcd_digit_adjust
  import bcd_pkg::*;
#(
  parameter bit ADD = 1'b0
) (
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  // ADD=0: reverse dabble (>=8 -> -3).
  // ADD=1: forward dabble (>=5 -> +3).
  if (ADD) begin : g_add
    assign dout = (din >= BCD_ADD_THRESH)
                ? din + BCD_ADJ_VAL
                : din;
  end else begin : g_sub
    assign dout = (din >= BCD_ADJ_THRESH)
                ? din - BCD_ADJ_VAL
                : din;
  end

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter (reverse double dabble).
// Ports: clk, reset, start/bcd_in in; ready, busy, done, binary_out, error out.
module bcd2bin_seq
  import bcd_pkg::*;
#(
  parameter int NDIGITS = 3,
  parameter int BIN_W   = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [4*NDIGITS-1:0]   bcd_in,
  output logic                   ready,
  output logic                   busy,
  output logic                   done,
  output logic [BIN_W-1:0]       binary_out,
  output logic                   error
);

  localparam int BCD_W = BCD_DIGIT_W * NDIGITS;
  localparam int CNT_W =
    (clog2(BIN_W) < 1) ? 1 : clog2(BIN_W);
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(BIN_W - 1);

  state_t state;
  state_t nxt;

  logic [BCD_W-1:0] bcd_sr;
  logic [BIN_W-1:0] bin_sr;
  logic [CNT_W-1:0] cnt;

  logic [BCD_W-1:0] bcd_sh;
  logic [BIN_W-1:0] bin_sh;
  logic [BCD_W-1:0] bcd_adj;

  logic accept;
  logic bad;
  logic last;

  assign ready  = (state != SHIFT);
  assign busy   = (state == SHIFT);
  assign done   = (state == DONE);
  assign accept = ready & start;
  assign last   = (cnt == LAST);

  // One-bit right shift of the whole {bcd,bin} pair.
  assign {bcd_sh, bin_sh} =
    {1'b0, bcd_sr, bin_sr[BIN_W-1:1]};

  for (genvar i = 0; i < NDIGITS; i++) begin : g_dig
    bcd_digit_adjust #(
      .ADD (1'b0)
    ) u_adj (
      .din  (bcd_sh[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dout (bcd_adj[i*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (bcd_in[i*BCD_DIGIT_W +: BCD_DIGIT_W]
          > BCD_MAX_DIGIT)
        bad = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE, DONE: begin
        if (accept) nxt = bad ? DONE : SHIFT;
        else        nxt = IDLE;
      end
      SHIFT: begin
        if (last) nxt = DONE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcd_sr     <= '0;
      bin_sr     <= '0;
      cnt        <= '0;
      binary_out <= '0;
      error      <= 1'b0;
    end else begin
      unique case (1'b1)
        accept: begin
          bcd_sr <= bcd_in;
          bin_sr <= '0;
          cnt    <= '0;
          error  <= bad;
          if (bad) binary_out <= '0;
        end
        busy: begin
          bcd_sr <= bcd_adj;
          bin_sr <= bin_sh;
          cnt    <= cnt + 1'b1;
          if (last) binary_out <= bin_sh;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed bench for bcd2bin_seq: latency, handshake, error, reset, sweep.
// Drives on negedge, samples on negedge; expectations are hand constants.
module tb_bcd2bin_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [11:0] bcd_in;
  logic        ready;
  logic        busy;
  logic        done;
  logic [9:0]  binary_out;
  logic        error;

  int pass_cnt;
  int total_cnt;
  int lat;
  logic busy_ok;

  bcd2bin_seq #(
    .NDIGITS (3),
    .BIN_W   (10)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bcd_in     (bcd_in),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .binary_out (binary_out),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total_cnt++;
    if (got !== exp)
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    else
      pass_cnt++;
  endtask

  // Wait for done from cycle 1 onward; lat ends as the done cycle.
  task automatic wait_done();
    lat = 1;
    busy_ok = 1'b1;
    while (!done && lat < 40) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run(
    input string      tag,
    input logic [11:0] v,
    input logic [9:0]  eb,
    input logic        ee,
    input int          el
  );
    @(negedge clk);
    start  = 1'b1;
    bcd_in = v;
    @(negedge clk);
    start  = 1'b0;
    bcd_in = 12'hfff;
    wait_done();
    check({tag, "_lat"}, lat, el);
    check({tag, "_bin"}, binary_out, eb);
    check({tag, "_err"}, error, ee);
    check({tag, "_rdy"}, ready, 1'b1);
    if (el > 1) check({tag, "_busy"}, busy_ok, 1'b1);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    reset  = 1'b1;
    start  = 1'b0;
    bcd_in = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_bin", binary_out, 10'd0);
    check("rst_err", error, 1'b0);
    reset = 1'b0;

    run("c999", 12'h999, 10'd999, 1'b0, 11);
    @(negedge clk);
    check("c999_pulse", done, 1'b0);
    check("c999_hold", binary_out, 10'd999);

    // Back-to-back with start held through DONE.
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 12'h000;
    @(negedge clk);
    bcd_in = 12'h255;
    wait_done();
    check("b2b0_lat", lat, 11);
    check("b2b0_bin", binary_out, 10'd0);
    check("b2b0_rdy", ready, 1'b1);
    @(negedge clk);
    start = 1'b0;
    check("b2b1_busy", busy, 1'b1);
    wait_done();
    check("b2b1_lat", lat, 11);
    check("b2b1_bin", binary_out, 10'd255);

    run("e0a5", 12'h0a5, 10'd0, 1'b1, 1);
    run("c105", 12'h105, 10'd105, 1'b0, 11);

    // Starts during SHIFT must be ignored.
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 12'h128;
    @(negedge clk);
    lat = 1;
    while (!done && lat < 40) begin
      start  = (lat == 3 || lat == 7);
      bcd_in = 12'h999;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check("ign_lat", lat, 11);
    check("ign_bin", binary_out, 10'd128);
    @(negedge clk);
    check("ign_pulse", done, 1'b0);
    check("ign_idle", busy, 1'b0);

    // Reset mid-SHIFT at cycle 5.
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 12'h640;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mrst_ready", ready, 1'b1);
    check("mrst_busy", busy, 1'b0);
    check("mrst_done", done, 1'b0);
    check("mrst_bin", binary_out, 10'd0);
    check("mrst_err", error, 1'b0);
    busy_ok = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (done || busy) busy_ok = 1'b0;
    end
    check("mrst_quiet", busy_ok, 1'b1);
    run("c640", 12'h640, 10'd640, 1'b0, 11);

    for (int d = 0; d < 1000; d++) begin
      logic [11:0] v;
      v[11:8] = 4'(d / 100);
      v[7:4]  = 4'((d / 10) % 10);
      v[3:0]  = 4'(d % 10);
      run($sformatf("sw%0d", d), v, 10'(d), 1'b0, 11);
    end

    $display("%0d/%0d checks passed",
             pass_cnt, total_cnt);
    $finish;
  end

endmodule
